// File: rtl/sm4_decrypt_core.sv
// SM4 block decryption core: one round per cycle, round keys read in reverse
// order from a 32-entry key buffer, output held until the consumer takes it.

module sm4_round (
  input  logic [127:0] x_i,
  input  logic [31:0]  rk_i,
  input  logic [31:0]  mask_i,
  input  logic         is_key_i,
  output logic [31:0]  o,
  output logic [31:0]  mask_o
);
  localparam logic [0:255][7:0] sbox_c = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  logic [31:0] t_m, t, b, lin;

  // Mask is applied to the S-box input and removed before lookup, so the
  // round output is always the unmasked value.
  always_comb begin
    t_m = x_i[63:32] ^ x_i[95:64] ^ x_i[127:96] ^ rk_i ^ mask_i;
    t   = t_m ^ mask_i;
    b   = {sbox_c[t[31:24]], sbox_c[t[23:16]], sbox_c[t[15:8]], sbox_c[t[7:0]]};
    if (is_key_i) lin = b ^ rotl(b, 13) ^ rotl(b, 23);
    else          lin = b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
    o      = x_i[31:0] ^ lin;
    mask_o = {mask_i[23:0], mask_i[31:24]};
  end
endmodule

// state | meaning
// IDLE  | ready for a ciphertext block, key buffer writable
// RUN   | one decryption round per cycle, counter 0..rounds_p-1
// DONE  | plaintext valid on data_o until data_yumi_i
module sm4_decrypt_core #(
  parameter int rounds_p     = 32,
  parameter int word_width_p = 32,
  parameter int group_size_p = 128
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    rkey_w_v_i,
  input  logic [4:0]              rkey_w_addr_i,
  input  logic [word_width_p-1:0] rkey_w_data_i,
  input  logic                    data_v_i,
  input  logic [group_size_p-1:0] data_i,
  input  logic [word_width_p-1:0] mask_i,
  output logic                    data_ready_o,
  output logic                    data_v_o,
  output logic [group_size_p-1:0] data_o,
  input  logic                    data_yumi_i,
  output logic                    busy_o
);
  localparam int cnt_w_lp = $clog2(rounds_p);
  localparam logic [cnt_w_lp-1:0] last_lp = cnt_w_lp'(rounds_p - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                  st_r, st_n;
  logic [cnt_w_lp-1:0]     cnt_r;
  logic [group_size_p-1:0] data_r, data_rev;
  logic [word_width_p-1:0] mask_r, mask_nxt, round_o, rkey;
  logic [word_width_p-1:0] rkey_mem [rounds_p];

  always_ff @(posedge clk_i)
    if (rkey_w_v_i && !busy_o) rkey_mem[rkey_w_addr_i] <= rkey_w_data_i;

  assign rkey = rkey_mem[last_lp - cnt_r];

  sm4_round u_round (
    .x_i      (data_r),
    .rk_i     (rkey),
    .mask_i   (mask_r),
    .is_key_i (1'b0),
    .o        (round_o),
    .mask_o   (mask_nxt)
  );

  always_comb begin
    data_rev = '0;
    for (int i = 0; i < 4; i++)
      data_rev[i*word_width_p +: word_width_p] = data_i[(3-i)*word_width_p +: word_width_p];
  end

  always_comb begin
    st_n = st_r;
    case (st_r)
      IDLE:    if (data_v_i) st_n = RUN;
      RUN:     if (cnt_r == last_lp) st_n = DONE;
      DONE:    if (data_yumi_i) st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      st_r   <= IDLE;
      cnt_r  <= '0;
      data_r <= '0;
      mask_r <= '0;
    end else begin
      st_r <= st_n;
      case (st_r)
        IDLE: if (data_v_i) begin
          data_r <= data_rev;
          mask_r <= mask_i;
          cnt_r  <= '0;
        end
        RUN: begin
          data_r <= {round_o, data_r[group_size_p-1:word_width_p]};
          mask_r <= mask_nxt;
          if (cnt_r != last_lp) cnt_r <= cnt_r + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign data_ready_o = (st_r == IDLE);
  assign busy_o       = (st_r != IDLE);
  assign data_v_o     = (st_r == DONE);
  assign data_o       = (st_r == DONE) ? data_r : '0;
endmodule
